// File: rtl/decoder_fec_controller.sv
// Hamming(7,4) decode controller: fetches codewords from a receive buffer, corrects
// single-bit errors, and presents the data nibble over a four-phase req/ack handshake.
module decoder_fec_controller #(
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 buff_empty,
    input  logic [6:0]           buff_data,
    output logic                 rd_en_buff,
    input  logic                 ack,
    output logic                 req,
    output logic [3:0]           data_out,
    output logic                 corrected,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 busy
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] READ    = 3'd1;
    localparam logic [2:0] CAPTURE = 3'd2;
    localparam logic [2:0] PRESENT = 3'd3;
    localparam logic [2:0] RELEASE = 3'd4;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       armed;
    logic [2:0] syndrome_c;
    logic [6:0] fixed_c;
    logic [3:0] data_c;

    // Syndrome value names the 1-based bit position to invert.
    always_comb begin
        syndrome_c = {buff_data[3] ^ buff_data[4] ^ buff_data[5] ^ buff_data[6],
                      buff_data[1] ^ buff_data[2] ^ buff_data[5] ^ buff_data[6],
                      buff_data[0] ^ buff_data[2] ^ buff_data[4] ^ buff_data[6]};
        fixed_c = buff_data;
        for (int i = 0; i < 7; i++) begin
            if (syndrome_c == 3'(i + 1)) begin
                fixed_c[i] = ~buff_data[i];
            end
        end
        data_c = {fixed_c[6], fixed_c[5], fixed_c[4], fixed_c[2]};
    end

    // armed stays low for the first cycle out of reset so no read follows reset directly.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (armed && en && !buff_empty) state_nxt = READ;
            READ:    state_nxt = CAPTURE;
            CAPTURE: state_nxt = PRESENT;
            PRESENT: if (ack) state_nxt = RELEASE;
            RELEASE: if (!ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            armed      <= 1'b0;
            rd_en_buff <= 1'b0;
            req        <= 1'b0;
            busy       <= 1'b0;
            data_out   <= 4'd0;
            corrected  <= 1'b0;
            err_count  <= '0;
        end else begin
            state      <= state_nxt;
            armed      <= 1'b1;
            rd_en_buff <= (state_nxt == READ);
            req        <= (state_nxt == PRESENT);
            busy       <= (state_nxt != IDLE);
            if (state == CAPTURE) begin
                data_out  <= data_c;
                corrected <= (syndrome_c != 3'd0);
                if ((syndrome_c != 3'd0) && (err_count != {ERR_CNT_W{1'b1}})) begin
                    err_count <= err_count + ERR_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/decoder_fec_controller.md
DECODER_FEC_CONTROLLER -- requirements
Module: decoder_fec_controller

Interface
REQ-001 Parameter: ERR_CNT_W, default 8, width of the corrected-error counter.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 en  input  1  block enable; new words are fetched only while high.
REQ-005 buff_empty  input  1  receive buffer holds no codeword.
REQ-006 buff_data  input  7  codeword from buffer, valid the cycle after rd_en_buff.
REQ-007 rd_en_buff  output  1  one-cycle buffer read strobe.
REQ-008 ack  input  1  consumer acknowledge, four-phase.
REQ-009 req  output  1  data_out/corrected valid, four-phase.
REQ-010 data_out  output  4  decoded data nibble.
REQ-011 corrected  output  1  high when the presented word had a nonzero syndrome.
REQ-012 err_count  output  ERR_CNT_W  saturating count of corrected words.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The codeword SHALL be Hamming(7,4): buff_data[i] is position i+1; parity at positions 1,2,4; data d[0..3] at positions 3,5,6,7.
REQ-015 Syndrome SHALL be {s3,s2,s1}: s1 = XOR of positions 1,3,5,7; s2 = XOR of 2,3,6,7; s3 = XOR of 4,5,6,7.
REQ-016 A nonzero syndrome S SHALL invert position S before data extraction; parity-position errors set corrected but leave data unchanged.
REQ-017 FSM states SHALL be IDLE, READ, CAPTURE, PRESENT, RELEASE.
REQ-018 IDLE -> READ when en=1 and buff_empty=0; otherwise stay.
REQ-019 READ lasts exactly one cycle with rd_en_buff=1; rd_en_buff SHALL be 0 in all other states.
REQ-020 CAPTURE lasts one cycle: buff_data sampled, corrected data, corrected flag registered; err_count incremented if syndrome nonzero.
REQ-021 PRESENT: req=1, data_out/corrected held stable; on ack=1 go to RELEASE.
REQ-022 RELEASE: req=0; on ack=0 go to IDLE.
REQ-023 Latency: en and !buff_empty sampled at edge N give rd_en_buff high in cycle N+1 and req high from cycle N+3.
REQ-024 ack high on entry to PRESENT SHALL still require one PRESENT cycle with req=1 before RELEASE.
REQ-025 ack ignored in IDLE, READ, CAPTURE.
REQ-026 en deassertion after READ SHALL not abort the current word; the handshake completes, then the FSM stays in IDLE.
REQ-027 buff_empty is sampled only in IDLE.
REQ-028 err_count SHALL saturate at 2^ERR_CNT_W-1 and not wrap.
REQ-029 data_out and corrected SHALL retain the last presented values after RELEASE until the next CAPTURE.
REQ-030 Throughput: at most one word per 5 cycles with immediate ack/ack-release.

Reset
REQ-031 rst=1 at a rising edge SHALL force IDLE, req=0, rd_en_buff=0, busy=0, data_out=0, corrected=0, err_count=0, in any state.
REQ-032 Reset mid-handshake SHALL drop req the next cycle; the word is discarded, no partial state retained.
REQ-033 No buffer read SHALL be issued in the cycle after rst deasserts.

Verification
REQ-034 buff_data=7'h55, en=1, ack echoes req -> data_out=4'b1011, corrected=0, err_count=0.
REQ-035 buff_data=7'h45 (position 5 flipped) -> data_out=4'b1011, corrected=1, err_count=1.
REQ-036 buff_data=7'h54 (position 1 flipped) -> data_out=4'b1011, corrected=1; buff_data=7'h00 -> data_out=0, corrected=0.
REQ-037 ack held low 20 cycles in PRESENT -> req stays 1, data_out stable, no rd_en_buff pulse; buffer non-empty throughout.
REQ-038 ERR_CNT_W=2, five corrected words -> err_count reads 1,2,3,3,3.
REQ-039 rst pulsed while req=1 -> next cycle req=0, err_count=0, busy=0; with buff_empty=0, en=1, rd_en_buff first rises two cycles after rst falls.
